// File: rtl/cpuc_ram_arbiter.sv
// Two-requester arbiter (0 = fetch, 1 = data) for a single-port RAM with a bounded ownership lock.
// Define CPUC_RAM_ARB_RR_EN for round-robin in IDLE; otherwise requester 1 has fixed priority.
module cpuc_ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_wren,
  input  logic [1:0]            req_lock,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_wren,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [1:0]            dbg_state,
  output logic [7:0]            dbg_lock_cnt
);

  // Handshake: requester i accesses the RAM in the cycle where req_valid[i] & req_ready[i];
  // its request fields must stay stable while valid & !ready, and rsp_valid[i] follows one cycle later.

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [8:0] LOCK_LIMIT = 9'(LOCK_MAX);

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  force_q, force_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  gnt_any, gnt_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [8:0]            cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    force_d      = 1'b0;
    cnt_d        = cnt_q;
    gnt_any      = 1'b0;
    gnt_idx      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req_valid == 2'b11) begin
            gnt_any = 1'b1;
            // After a forced release the other requester wins regardless of policy.
            if (force_q) gnt_idx = ~last_grant_q;
            else begin
`ifdef CPUC_RAM_ARB_RR_EN
              gnt_idx = ~last_grant_q;
`else
              gnt_idx = 1'b1;
`endif
            end
          end else if (req_valid != 2'b00) begin
            gnt_any = 1'b1;
            gnt_idx = req_valid[1];
          end
        end
        OWN0: begin
          if (req_valid[0]) gnt_any = 1'b1;
          else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
        OWN1: begin
          gnt_idx = 1'b1;
          if (req_valid[1]) gnt_any = 1'b1;
          else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase

      if (gnt_any) begin
        last_grant_d = gnt_idx;
        if (req_lock[gnt_idx] && (cnt_inc < LOCK_LIMIT)) begin
          state_d = gnt_idx ? OWN1 : OWN0;
          cnt_d   = cnt_inc[7:0];
        end else begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          force_d = req_lock[gnt_idx];
        end
      end
    end
  end

  assign req_ready    = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign sel_addr     = gnt_idx ? req_addr1 : req_addr0;
  assign sel_wdata    = gnt_idx ? req_wdata1 : req_wdata0;
  assign ram_address  = gnt_any ? sel_addr : addr_q;
  assign ram_data     = gnt_any ? sel_wdata : '0;
  assign ram_wren     = gnt_any & req_wren[gnt_idx];
  assign dbg_state    = state_q;
  assign dbg_lock_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      force_q      <= 1'b0;
      cnt_q        <= 8'd0;
      addr_q       <= '0;
      rsp_valid    <= 2'b00;
      rsp_rdata    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      force_q      <= force_d;
      cnt_q        <= cnt_d;
      rsp_valid    <= req_ready;
      if (gnt_any) begin
        addr_q    <= sel_addr;
        rsp_rdata <= req_wren[gnt_idx] ? '0 : ram_q;
      end
    end
  end

endmodule

// File: tb/tb_cpuc_ram_arbiter.sv
// Table-driven bench for cpuc_ram_arbiter with a behavioural RAM; follows CPUC_RAM_ARB_RR_EN if defined.
module tb_cpuc_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_wren, req_lock, req_ready, rsp_valid, dbg_state;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [31:0] rsp_rdata, ram_address, ram_data, ram_q;
  logic        ram_wren;
  logic [7:0]  dbg_lock_cnt;
  logic [31:0] mem [256];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  valid, wren, lock;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  e_ready;
    logic        e_wren;
    logic [31:0] e_addr;
    logic [1:0]  e_rsp;
    logic [31:0] e_rdata;
    logic [1:0]  e_state;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl [10];

  cpuc_ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wren(req_wren), .req_lock(req_lock),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q),
    .dbg_state(dbg_state), .dbg_lock_cnt(dbg_lock_cnt)
  );

  always #5 clk = ~clk;

  assign ram_q = mem[ram_address[7:0]];
  always @(posedge clk) if (ram_wren) mem[ram_address[7:0]] <= ram_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] valid, wren, lock, input logic [31:0] a0, a1, d0, d1,
                              input logic [1:0] e_ready, input logic e_wren, input logic [31:0] e_addr,
                              input logic [1:0] e_rsp, input logic [31:0] e_rdata,
                              input logic [1:0] e_state, input logic [7:0] e_cnt);
    vec_t v;
    v.valid = valid; v.wren = wren; v.lock = lock;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.e_ready = e_ready; v.e_wren = e_wren; v.e_addr = e_addr;
    v.e_rsp = e_rsp; v.e_rdata = e_rdata; v.e_state = e_state; v.e_cnt = e_cnt;
    return v;
  endfunction

  // One cycle: drive at negedge, check grant/RAM drive mid-cycle, check registered state after the edge.
  task automatic step(input logic r, input vec_t v, input string tag);
    @(negedge clk);
    rst = r;
    req_valid = v.valid; req_wren = v.wren; req_lock = v.lock;
    req_addr0 = v.a0; req_addr1 = v.a1; req_wdata0 = v.d0; req_wdata1 = v.d1;
    #1;
    chk({tag, " req_ready"}, 32'(req_ready), 32'(v.e_ready));
    chk({tag, " ram_wren"}, 32'(ram_wren), 32'(v.e_wren));
    chk({tag, " ram_address"}, ram_address, v.e_addr);
    if (v.e_wren) chk({tag, " ram_data"}, ram_data, v.e_ready[1] ? v.d1 : v.d0);
    @(posedge clk);
    #1;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v.e_rsp));
    if (v.e_rsp != 2'b00) chk({tag, " rsp_rdata"}, rsp_rdata, v.e_rdata);
    chk({tag, " state"}, 32'(dbg_state), 32'(v.e_state));
    chk({tag, " lock_cnt"}, 32'(dbg_lock_cnt), 32'(v.e_cnt));
  endtask

  initial begin
    logic [1:0] r;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst = 1'b1;
    req_valid = 2'b11; req_wren = 2'b00; req_lock = 2'b00;
    req_addr0 = 32'h0; req_addr1 = 32'h4; req_wdata0 = 32'h0; req_wdata1 = 32'h0;
    @(posedge clk);

    // Reset held with both requesters asking: nothing granted, nothing responds.
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 0, 0, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 2'd0, 8'd0), "reset");
    chk("reset rsp_rdata", rsp_rdata, 32'h0);

`ifdef CPUC_RAM_ARB_RR_EN
    tbl[0] = mk(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 0, 0, 2'b01, 1'b0, 32'h0, 2'b01, 32'hA000_0000, 2'd0, 8'd0);
`else
    tbl[0] = mk(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 0, 0, 2'b10, 1'b0, 32'h4, 2'b10, 32'hA000_0004, 2'd0, 8'd0);
`endif
    tbl[1] = mk(2'b10, 2'b10, 2'b00, 32'h0, 32'h10, 0, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h10, 2'b10, 32'h0, 2'd0, 8'd0);
    tbl[2] = mk(2'b10, 2'b00, 2'b00, 32'h0, 32'h10, 0, 0, 2'b10, 1'b0, 32'h10, 2'b10, 32'hDEAD_BEEF, 2'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef CPUC_RAM_ARB_RR_EN
      r = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      r = 2'b10;
`endif
      tbl[3+i] = mk(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 0, 0, r, 1'b0, r[1] ? 32'h4 : 32'h0, r,
                    r[1] ? 32'hA000_0004 : 32'hA000_0000, 2'd0, 8'd0);
    end
    tbl[7] = mk(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0, 2'b00, 1'b0, 32'h4, 2'b00, 32'h0, 2'd0, 8'd0);
    tbl[8] = mk(2'b01, 2'b01, 2'b00, 32'h20, 32'h0, 32'h1234_5678, 0, 2'b01, 1'b1, 32'h20, 2'b01, 32'h0, 2'd0, 8'd0);
    tbl[9] = mk(2'b01, 2'b00, 2'b00, 32'h20, 32'h0, 0, 0, 2'b01, 1'b0, 32'h20, 2'b01, 32'h1234_5678, 2'd0, 8'd0);
    for (int i = 0; i < 10; i++) step(1'b0, tbl[i], $sformatf("vec%0d", i));

    // Requester 0 locks for LOCK_MAX grants while requester 1 waits, then is forced through.
    step(1'b0, mk(2'b01, 2'b00, 2'b01, 32'h8, 32'hC, 0, 0, 2'b01, 1'b0, 32'h8, 2'b01, 32'hA000_0008, 2'd1, 8'd1), "lock0 c1");
    for (int k = 2; k <= 8; k++)
      step(1'b0, mk(2'b11, 2'b00, 2'b01, 32'h8, 32'hC, 0, 0, 2'b01, 1'b0, 32'h8, 2'b01, 32'hA000_0008,
                    (k < 8) ? 2'd1 : 2'd0, (k < 8) ? 8'(k) : 8'd0), $sformatf("lock0 c%0d", k));
    step(1'b0, mk(2'b11, 2'b00, 2'b01, 32'h8, 32'hC, 0, 0, 2'b10, 1'b0, 32'hC, 2'b10, 32'hA000_000C, 2'd0, 8'd0), "lock0 c9");

    // Requester 1 locks to the limit; the override must hand the next cycle to requester 0.
    step(1'b0, mk(2'b10, 2'b00, 2'b10, 32'h8, 32'hC, 0, 0, 2'b10, 1'b0, 32'hC, 2'b10, 32'hA000_000C, 2'd2, 8'd1), "lock1 c1");
    for (int k = 2; k <= 8; k++)
      step(1'b0, mk(2'b11, 2'b00, 2'b10, 32'h8, 32'hC, 0, 0, 2'b10, 1'b0, 32'hC, 2'b10, 32'hA000_000C,
                    (k < 8) ? 2'd2 : 2'd0, (k < 8) ? 8'(k) : 8'd0), $sformatf("lock1 c%0d", k));
    step(1'b0, mk(2'b11, 2'b00, 2'b00, 32'h8, 32'hC, 0, 0, 2'b01, 1'b0, 32'h8, 2'b01, 32'hA000_0008, 2'd0, 8'd0), "lock1 c9");

    // Owner drops valid mid-lock: release, then requester 1 granted the next cycle.
    step(1'b0, mk(2'b01, 2'b00, 2'b01, 32'h8, 32'hC, 0, 0, 2'b01, 1'b0, 32'h8, 2'b01, 32'hA000_0008, 2'd1, 8'd1), "drop c1");
    step(1'b0, mk(2'b11, 2'b00, 2'b01, 32'h8, 32'hC, 0, 0, 2'b01, 1'b0, 32'h8, 2'b01, 32'hA000_0008, 2'd1, 8'd2), "drop c2");
    step(1'b0, mk(2'b10, 2'b00, 2'b00, 32'h8, 32'hC, 0, 0, 2'b00, 1'b0, 32'h8, 2'b00, 32'h0, 2'd0, 8'd0), "drop c3");
    step(1'b0, mk(2'b10, 2'b00, 2'b00, 32'h8, 32'hC, 0, 0, 2'b10, 1'b0, 32'hC, 2'b10, 32'hA000_000C, 2'd0, 8'd0), "drop c4");

    // Reset lands at lock_cnt=3: FSM idles and the response due that cycle is dropped.
    for (int k = 1; k <= 3; k++)
      step(1'b0, mk(2'b01, 2'b00, 2'b01, 32'h8, 32'hC, 0, 0, 2'b01, 1'b0, 32'h8, 2'b01, 32'hA000_0008, 2'd1, 8'(k)),
           $sformatf("rstlock c%0d", k));
    step(1'b1, mk(2'b01, 2'b00, 2'b01, 32'h8, 32'hC, 0, 0, 2'b00, 1'b0, 32'h8, 2'b00, 32'h0, 2'd0, 8'd0), "rstlock rst");
    step(1'b0, mk(2'b01, 2'b00, 2'b00, 32'h8, 32'hC, 0, 0, 2'b01, 1'b0, 32'h8, 2'b01, 32'hA000_0008, 2'd0, 8'd0), "rstlock after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
